// File: rtl/wb_i2c_bus_if_if.sv
// Bus bundle for wb_i2c_bus_if: request/response handshake, Wishbone master pins,
// I2C slave pins and FSM debug state.
interface wb_i2c_bus_if_if #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8
);
  // Handshake: a request transfers on any cycle where req_valid && req_ready; the
  // requester holds req_* stable until then. rsp_valid is a one-cycle pulse with no
  // backpressure, and req_ready is high again in that same cycle.
  logic                      req_valid;
  logic                      req_we;
  logic [WB_ADDR_WIDTH-1:0]  req_adr;
  logic [WB_DATA_WIDTH-1:0]  req_wdata;
  logic                      req_ready;
  logic                      rsp_valid;
  logic [WB_DATA_WIDTH-1:0]  rsp_rdata;
  logic                      cyc_o;
  logic                      stb_o;
  logic                      we_o;
  logic [WB_ADDR_WIDTH-1:0]  adr_o;
  logic [WB_DATA_WIDTH-1:0]  dat_o;
  logic [WB_DATA_WIDTH-1:0]  dat_i;
  logic                      ack_i;
  logic                      irq_i;
  logic                      irq_o;
  logic                      scl;
  logic                      sda_i;
  logic                      sda_oe;
  logic                      i2c_op;
  logic [I2C_ADDR_WIDTH-1:0] i2c_adr;
  logic                      wr_valid;
  logic [I2C_DATA_WIDTH-1:0] wr_data;
  logic [I2C_DATA_WIDTH-1:0] rd_data;
  logic                      rd_req;
  logic                      xfer_done;
  logic                      wb_state;
  logic [2:0]                i2c_state;

  modport slave (
    input  req_valid, req_we, req_adr, req_wdata, dat_i, ack_i, irq_i, scl, sda_i, rd_data,
    output req_ready, rsp_valid, rsp_rdata, cyc_o, stb_o, we_o, adr_o, dat_o, irq_o,
    output sda_oe, i2c_op, i2c_adr, wr_valid, wr_data, rd_req, xfer_done, wb_state, i2c_state
  );

  modport master (
    output req_valid, req_we, req_adr, req_wdata, dat_i, ack_i, irq_i, scl, sda_i, rd_data,
    input  req_ready, rsp_valid, rsp_rdata, cyc_o, stb_o, we_o, adr_o, dat_o, irq_o,
    input  sda_oe, i2c_op, i2c_adr, wr_valid, wr_data, rd_req, xfer_done, wb_state, i2c_state
  );
endinterface

// File: rtl/wb_i2c_bus_if.sv
// Wishbone single-cycle master plus an I2C slave responder on one SCL/SDA pair.
// The two engines are independent and share only clock and reset.
module wb_i2c_bus_if #(
  parameter int                        WB_ADDR_WIDTH  = 2,
  parameter int                        WB_DATA_WIDTH  = 8,
  parameter int                        I2C_ADDR_WIDTH = 7,
  parameter int                        I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22
) (
  input logic            clk_i,
  input logic            rst_i,
  wb_i2c_bus_if_if.slave bus
);
  localparam logic [3:0] BYTE_BITS = 4'(I2C_DATA_WIDTH);

  typedef enum logic {WB_IDLE, WB_BUS} wb_state_t;
  typedef enum logic [2:0] {
    I_IDLE, I_ADDR, I_ADDR_ACK, I_WR, I_WR_ACK, I_RD, I_RD_ACK, I_WAIT_STOP
  } i2c_state_t;

  wb_state_t  wb_st;
  i2c_state_t i2c_st;

  assign bus.wb_state  = wb_st;
  assign bus.i2c_state = i2c_st;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_st         <= WB_IDLE;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.cyc_o     <= 1'b0;
      bus.stb_o     <= 1'b0;
      bus.we_o      <= 1'b0;
      bus.adr_o     <= '0;
      bus.dat_o     <= '0;
      bus.irq_o     <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.irq_o     <= bus.irq_i;
      case (wb_st)
        WB_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.cyc_o     <= 1'b1;
            bus.stb_o     <= 1'b1;
            bus.we_o      <= bus.req_we;
            bus.adr_o     <= bus.req_adr;
            bus.dat_o     <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            wb_st         <= WB_BUS;
          end
        end
        WB_BUS: begin
          if (bus.ack_i) begin
            bus.rsp_rdata <= bus.we_o ? '0 : bus.dat_i;
            bus.rsp_valid <= 1'b1;
            bus.cyc_o     <= 1'b0;
            bus.stb_o     <= 1'b0;
            bus.we_o      <= 1'b0;
            bus.req_ready <= 1'b1;
            wb_st         <= WB_IDLE;
          end
        end
        default: wb_st <= WB_IDLE;
      endcase
    end
  end

  // Two synchronizer stages plus one history stage; idle bus level is high.
  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl};
      sda_sync <= {sda_sync[0], bus.sda_i};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_cond, stop_cond;
  assign scl_s      = scl_sync[1];
  assign sda_s      = sda_sync[1];
  assign scl_rise   = scl_s & ~scl_d;
  assign scl_fall   = ~scl_s & scl_d;
  assign start_cond = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_cond  = scl_s & scl_d & ~sda_d & sda_s;

  logic [I2C_DATA_WIDTH-1:0] shreg;
  logic [3:0]                bit_cnt;
  logic                      addressed;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i2c_st        <= I_IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      addressed     <= 1'b0;
      bus.sda_oe    <= 1'b0;
      bus.i2c_op    <= 1'b0;
      bus.i2c_adr   <= '0;
      bus.wr_valid  <= 1'b0;
      bus.wr_data   <= '0;
      bus.rd_req    <= 1'b0;
      bus.xfer_done <= 1'b0;
    end else begin
      bus.wr_valid  <= 1'b0;
      bus.rd_req    <= 1'b0;
      bus.xfer_done <= 1'b0;
      // Bus conditions win over any bit activity seen in the same cycle.
      if (stop_cond) begin
        i2c_st        <= I_IDLE;
        bus.sda_oe    <= 1'b0;
        bus.xfer_done <= addressed;
        addressed     <= 1'b0;
      end else if (start_cond) begin
        i2c_st     <= I_ADDR;
        bus.sda_oe <= 1'b0;
        bit_cnt    <= '0;
      end else begin
        case (i2c_st)
          I_ADDR, I_WR: begin
            if (scl_rise && bit_cnt != BYTE_BITS) begin
              shreg   <= {shreg[I2C_DATA_WIDTH-2:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == BYTE_BITS) begin
              bit_cnt <= '0;
              if (i2c_st == I_WR) begin
                bus.wr_valid <= 1'b1;
                bus.wr_data  <= shreg;
                bus.sda_oe   <= 1'b1;
                i2c_st       <= I_WR_ACK;
              end else if (shreg[I2C_DATA_WIDTH-1:1] == SLAVE_ADDR) begin
                bus.i2c_adr <= shreg[I2C_DATA_WIDTH-1:1];
                bus.i2c_op  <= shreg[0];
                addressed   <= 1'b1;
                bus.sda_oe  <= 1'b1;
                i2c_st      <= I_ADDR_ACK;
              end else begin
                i2c_st <= I_IDLE;
              end
            end
          end
          I_ADDR_ACK, I_WR_ACK, I_RD_ACK: begin
            if (scl_rise) begin
              // Only a read ACK slot samples the master; a high level there is a NACK.
              if (i2c_st == I_RD_ACK && sda_s) i2c_st <= I_WAIT_STOP;
              else bit_cnt <= 4'd1;
            end else if (scl_fall && bit_cnt == 4'd1) begin
              if (i2c_st == I_RD_ACK || (i2c_st == I_ADDR_ACK && bus.i2c_op)) begin
                bus.rd_req <= 1'b1;
                bus.sda_oe <= ~bus.rd_data[I2C_DATA_WIDTH-1];
                shreg      <= {bus.rd_data[I2C_DATA_WIDTH-2:0], 1'b0};
                i2c_st     <= I_RD;
              end else begin
                bus.sda_oe <= 1'b0;
                bit_cnt    <= '0;
                i2c_st     <= I_WR;
              end
            end
          end
          I_RD: begin
            if (scl_fall) begin
              if (bit_cnt == BYTE_BITS) begin
                bus.sda_oe <= 1'b0;
                bit_cnt    <= '0;
                i2c_st     <= I_RD_ACK;
              end else begin
                bus.sda_oe <= ~shreg[I2C_DATA_WIDTH-1];
                shreg      <= {shreg[I2C_DATA_WIDTH-2:0], 1'b0};
                bit_cnt    <= bit_cnt + 4'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_wb_i2c_bus_if.sv
// Directed bench for wb_i2c_bus_if: Wishbone request cycles, I2C write/read/NACK
// transfers driven by a bit-level master model, and reset during a read byte.
module tb_wb_i2c_bus_if;
  localparam int Q = 80;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_i2c_bus_if_if bus ();

  logic scl_m, sda_m, sda_line, rd_zero;
  int   rd_cnt, xfer_cnt;
  logic oe_seen;
  assign sda_line     = sda_m & ~bus.sda_oe;
  assign bus.scl      = scl_m;
  assign bus.sda_i    = sda_line;
  assign bus.rd_data  = rd_zero ? 8'h00 : 8'(32'h64 + rd_cnt);

  wb_i2c_bus_if dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.wr_valid) got_q.push_back(bus.wr_data);
    if (bus.rd_req) rd_cnt++;
    if (bus.xfer_done) xfer_cnt++;
    if (bus.sda_oe) oe_seen = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // Called at a negedge; returns at the negedge where rsp_valid should be high.
  task automatic wb_req(input logic we, input logic [1:0] adr, input logic [7:0] wd,
                        input int ack_dly, input logic [7:0] rd, output int ncyc);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_adr = adr; bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    ncyc = 0;
    for (int k = 0; k < 64; k++) begin
      if (!bus.cyc_o) break;
      ncyc++;
      if (ncyc == 1) begin
        check("wb_adr", 32'(bus.adr_o), 32'(adr));
        check("wb_we", 32'(bus.we_o), 32'(we));
        check("wb_busy", 32'(bus.req_ready), 0);
        if (we) check("wb_dat", 32'(bus.dat_o), 32'(wd));
      end
      if (ncyc == ack_dly + 1) begin bus.ack_i = 1'b1; bus.dat_i = rd; end
      @(negedge clk);
      bus.ack_i = 1'b0; bus.dat_i = 8'h00;
    end
    check("wb_rsp_valid", 32'(bus.rsp_valid), 1);
    check("wb_ready_back", 32'(bus.req_ready), 1);
    check("wb_rdata", 32'(bus.rsp_rdata), we ? 32'h0 : 32'(rd));
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b; #Q; scl_m = 1'b1; #Q; s = sda_line; #Q; scl_m = 1'b0; #Q;
  endtask

  int bit_errs;
  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(d[i], s);
      if (s !== d[i]) bit_errs++;
    end
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(nack, s);
  endtask

  task automatic check_wr_queue(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int n, acks;
    logic ack;
    logic [7:0] d;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_adr = '0; bus.req_wdata = '0;
    bus.ack_i = 1'b0; bus.dat_i = '0; bus.irq_i = 1'b0;
    scl_m = 1'b1; sda_m = 1'b1; rd_zero = 1'b0; rd_cnt = 0; xfer_cnt = 0;
    oe_seen = 1'b0; bit_errs = 0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 1);
    check("rst_cyc", 32'(bus.cyc_o), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_sda_oe", 32'(bus.sda_oe), 0);
    check("rst_wb_state", 32'(bus.wb_state), 0);
    check("rst_i2c_state", 32'(bus.i2c_state), 0);
    rst = 1'b0;
    @(negedge clk);

    // Interrupt passthrough and stray ack outside a cycle.
    bus.irq_i = 1'b1; bus.ack_i = 1'b1;
    @(negedge clk);
    check("irq_o", 32'(bus.irq_o), 1);
    check("stray_ack_rsp", 32'(bus.rsp_valid), 0);
    check("stray_ack_cyc", 32'(bus.cyc_o), 0);
    bus.irq_i = 1'b0; bus.ack_i = 1'b0;
    @(negedge clk);

    // Test 1: write, ack after 3 wait cycles -> 4 cycles of cyc/stb.
    wb_req(1'b1, 2'd2, 8'h06, 3, 8'hEE, n);
    check("t1_cyc_cycles", 32'(n), 4);
    @(negedge clk);
    check("t1_rsp_pulse", 32'(bus.rsp_valid), 0);

    // Test 2: read then back-to-back write accepted in the response cycle.
    wb_req(1'b0, 2'd1, 8'h00, 1, 8'h80, n);
    check("t2_cyc_cycles", 32'(n), 2);
    wb_req(1'b1, 2'd3, 8'h5A, 0, 8'h00, n);
    check("t2_b2b_cycles", 32'(n), 1);
    @(negedge clk);

    // Test 3: write 0x00..0x1F to 0x22.
    i2c_start();
    write_byte(8'h44, ack);
    check("t3_addr_ack", 32'(ack), 1);
    check("t3_i2c_op", 32'(bus.i2c_op), 0);
    check("t3_i2c_adr", 32'(bus.i2c_adr), 32'h22);
    acks = 0;
    for (int i = 0; i < 32; i++) begin
      write_byte(8'(i), ack);
      exp_q.push_back(8'(i));
      if (ack) acks++;
    end
    i2c_stop();
    repeat (8) @(negedge clk);
    check("t3_data_acks", 32'(acks), 32);
    check("t3_no_stray_pull", 32'(bit_errs), 0);
    check("t3_xfer_done", 32'(xfer_cnt), 1);
    check_wr_queue("t3_wr");

    // Test 4: read 32 bytes, NACK the last one.
    rd_cnt = 0;
    i2c_start();
    write_byte(8'h45, ack);
    check("t4_addr_ack", 32'(ack), 1);
    check("t4_i2c_op", 32'(bus.i2c_op), 1);
    for (int i = 0; i < 32; i++) begin
      read_byte(i == 31, d);
      check("t4_rd_byte", 32'(d), 32'(8'h64 + i));
    end
    check("t4_released", 32'(bus.sda_oe), 0);
    oe_seen = 1'b0;
    i2c_stop();
    repeat (8) @(negedge clk);
    check("t4_no_drive_after_nack", 32'(oe_seen), 0);
    check("t4_rd_req_count", 32'(rd_cnt), 32);
    check("t4_xfer_done", 32'(xfer_cnt), 2);
    check("t4_no_wr", 32'(got_q.size()), 0);

    // Test 5: wrong address ignored, repeated START to 0x22 then ACKed.
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'h46, ack);
    check("t5_addr_nack", 32'(ack), 0);
    write_byte(8'h55, ack);
    check("t5_data_nack", 32'(ack), 0);
    check("t5_oe_never", 32'(oe_seen), 0);
    check("t5_no_wr", 32'(got_q.size()), 0);
    i2c_start();
    write_byte(8'h44, ack);
    check("t5_rs_addr_ack", 32'(ack), 1);
    write_byte(8'hA5, ack);
    check("t5_rs_data_ack", 32'(ack), 1);
    exp_q.push_back(8'hA5);
    i2c_stop();
    repeat (8) @(negedge clk);
    check("t5_xfer_done", 32'(xfer_cnt), 3);
    check_wr_queue("t5_wr");

    // Test 6: reset while the slave drives a 0 bit and a WB cycle is open.
    rd_zero = 1'b1;
    i2c_start();
    write_byte(8'h45, ack);
    check("t6_addr_ack", 32'(ack), 1);
    check("t6_driving", 32'(bus.sda_oe), 1);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_adr = 2'd0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("t6_cyc_open", 32'(bus.cyc_o), 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_sda_released", 32'(bus.sda_oe), 0);
    check("t6_cyc_abort", 32'(bus.cyc_o), 0);
    check("t6_req_ready", 32'(bus.req_ready), 1);
    check("t6_wb_idle", 32'(bus.wb_state), 0);
    check("t6_i2c_idle", 32'(bus.i2c_state), 0);
    rst = 1'b0;
    scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
    repeat (4) @(negedge clk);
    check("t6_still_released", 32'(bus.sda_oe), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
